rle_decoder: RTL

//  Downstream stage of the RLE encoder. Consumes the encoded byte stream (Data_out/Data_valid of
//  the encoder) and re-expands it to the original byte sequence. An input FIFO absorbs the encoded

---
 rtl/rle_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rle_decoder.sv
// rle_decoder: expands an RLE-encoded byte stream (literals and ESC,N,S run
// records) back to the original bytes. An input FIFO decouples the encoder
// from the expansion, and the output uses a valid/ready handshake.
module rle_decoder #(
    parameter logic [7:0] ESC_CHAR   = 8'h1B,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic       fast_clock,
    input  logic       start,
    input  logic       Enable,
    input  logic [7:0] Data_In,
    input  logic       Data_valid_in,
    output logic       In_ready,
    output logic [7:0] Data_out,
    output logic       Data_valid,
    input  logic       Out_ready,
    output logic       Overflow
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        GOT_ESC      = 3'd1,
        GOT_SYM_SKIP = 3'd2,
        GOT_CNT      = 3'd3,
        EXPAND       = 3'd4
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic [7:0]    head_s;
    logic          slot_free_s;
    logic          can_pop_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [7:0]    cnt_r;
    logic [7:0]    cnt_nxt_s;
    logic [7:0]    sym_r;
    logic [7:0]    sym_nxt_s;
    logic          load_s;
    logic [7:0]    load_data_s;

    logic [7:0]    data_out_r;
    logic          data_valid_r;
    logic          overflow_r;
    logic          in_ready_r;

    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == {(AW+1){1'b0}});
    assign head_s      = mem_r[rd_ptr_r];
    // The slot frees on the same edge the consumer takes the current byte.
    assign slot_free_s = ~data_valid_r | Out_ready;
    assign can_pop_s   = Enable & ~empty_s & slot_free_s;
    // A full FIFO can still take a byte when one leaves on the same edge.
    assign push_s      = Data_valid_in & (~full_s | pop_s);
    assign drop_s      = Data_valid_in & full_s & ~pop_s;

    // Next FIFO occupancy, used for the counter and the registered In_ready.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge fast_clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= Data_In;
        end
    end

    // FIFO pointers, occupancy, ready flag and sticky overflow.
    always_ff @(posedge fast_clock) begin
        if (start) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            in_ready_r <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != DEPTH_C);
            if (drop_s) overflow_r <= 1'b1;
        end
    end

    // Decoder next-state: decides pops, output loads and run-count updates.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sym_nxt_s   = sym_r;
        load_s      = 1'b0;
        load_data_s = 8'h00;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (can_pop_s) begin
                    pop_s = 1'b1;
                    if (head_s == ESC_CHAR) begin
                        state_nxt_s = GOT_ESC;
                    end else begin
                        load_s      = 1'b1;
                        load_data_s = head_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            GOT_ESC: begin
                if (can_pop_s) begin
                    pop_s       = 1'b1;
                    cnt_nxt_s   = head_s;
                    state_nxt_s = (head_s == 8'h00) ? GOT_SYM_SKIP : GOT_CNT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            GOT_SYM_SKIP: begin
                if (can_pop_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            GOT_CNT: begin
                if (can_pop_s) begin
                    pop_s       = 1'b1;
                    sym_nxt_s   = head_s;
                    load_s      = 1'b1;
                    load_data_s = head_s;
                    cnt_nxt_s   = (cnt_r != 8'd0) ? (cnt_r - 8'd1) : 8'd0;
                    state_nxt_s = (cnt_r <= 8'd1) ? IDLE : EXPAND;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            EXPAND: begin
                if (Enable && slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = sym_r;
                    cnt_nxt_s   = (cnt_r != 8'd0) ? (cnt_r - 8'd1) : 8'd0;
                    state_nxt_s = (cnt_r <= 8'd1) ? IDLE : EXPAND;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Decoder state, run count and run symbol registers.
    always_ff @(posedge fast_clock) begin
        if (start) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            sym_r   <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sym_r   <= sym_nxt_s;
        end
    end

    // Output slot: load a new byte, or clear valid once the consumer takes it.
    always_ff @(posedge fast_clock) begin
        if (start) begin
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
        end else if (load_s) begin
            data_out_r   <= load_data_s;
            data_valid_r <= 1'b1;
        end else if (Out_ready) begin
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= data_valid_r;
        end
    end

    assign Data_out   = data_out_r;
    assign Data_valid = data_valid_r;
    assign Overflow   = overflow_r;
    assign In_ready   = in_ready_r;

endmodule
